// File: rtl/mt_stream_gen.sv
// Mersenne Twister generator (MT19937 / MT19937-64) with a valid/ready output stream.
// The state array is seeded, twisted in place one word per cycle, then tempered out in index order.
module mt_stream_gen #(
    parameter int           W = 32,
    parameter int           N = 624,
    parameter int           M = 397,
    parameter int           R = 31,
    parameter logic [W-1:0] A = 'h9908B0DF,
    parameter int           U = 11,
    parameter logic [W-1:0] D = 'hFFFFFFFF,
    parameter int           S = 7,
    parameter logic [W-1:0] B = 'h9D2C5680,
    parameter int           T = 15,
    parameter logic [W-1:0] C = 'hEFC60000,
    parameter int           L = 18,
    parameter logic [W-1:0] F = 1812433253
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_valid,
    input  logic [W-1:0] seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int AW = $clog2(N);
    localparam int IW = $clog2(N + 1);
    localparam logic [W-1:0]  LOWER = (W'(1) << R) - W'(1);
    localparam logic [W-1:0]  UPPER = ~LOWER;
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW-1:0] WORDS = IW'(N);
    localparam logic [IW:0]   MID   = (IW + 1)'(M);
    localparam logic [IW:0]   SPAN  = (IW + 1)'(N);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_TWIST = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  prev;
    logic [W-1:0]  mt [N];

    logic [AW-1:0] cur_addr;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] mid_addr;
    logic [IW:0]   mid_sum;
    logic [W-1:0]  y;
    logic [W-1:0]  twist_word;
    logic [W-1:0]  init_word;
    logic [W-1:0]  t0;
    logic [W-1:0]  t1;
    logic [W-1:0]  t2;
    logic [W-1:0]  t3;
    logic [W-1:0]  tempered;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    // Reads are combinational on the register array, so wrapped indices in the
    // twist naturally see words already rewritten earlier in the same pass.
    always_comb begin
        cur_addr   = (idx < WORDS) ? AW'(idx) : '0;
        next_addr  = (idx >= LAST) ? '0 : AW'(idx + IW'(1));
        mid_sum    = {1'b0, idx} + MID;
        mid_addr   = (mid_sum >= SPAN) ? AW'(mid_sum - SPAN) : AW'(mid_sum);
        y          = (mt[cur_addr] & UPPER) | (mt[next_addr] & LOWER);
        twist_word = mt[mid_addr] ^ (y >> 1) ^ (y[0] ? A : '0);
        init_word  = F * (prev ^ (prev >> (W - 2))) + W'(idx);
        t0         = mt[cur_addr];
        t1         = t0 ^ ((t0 >> U) & D);
        t2         = t1 ^ ((t1 << S) & B);
        t3         = t2 ^ ((t2 << T) & C);
        tempered   = t3 ^ (t3 >> L);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (seed_valid) begin
            wr_en   = 1'b1;
            wr_data = seed;
        end else if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = AW'(idx);
            wr_data = init_word;
        end else if (state == ST_TWIST) begin
            wr_en   = 1'b1;
            wr_addr = AW'(idx);
            wr_data = twist_word;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mt[wr_addr] <= wr_data;
        end
    end

    // A seed always wins: any word still held in the output register is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            prev      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (seed_valid) begin
            state     <= ST_INIT;
            idx       <= IW'(1);
            prev      <= seed;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    prev <= init_word;
                    if (idx == LAST) begin
                        state <= ST_TWIST;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_TWIST: begin
                    if (idx == LAST) begin
                        state <= ST_RUN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_RUN: begin
                    // Regenerate only once the last word of the block has left the register.
                    if (!out_valid || out_ready) begin
                        if (idx == WORDS) begin
                            out_valid <= 1'b0;
                            state     <= ST_TWIST;
                            idx       <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= tempered;
                            idx       <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == ST_INIT) || (state == ST_TWIST);

endmodule

// File: tb/tb_mt_stream_gen.sv
// Self-checking bench for mt_stream_gen: a software MT19937 model feeds a scoreboard queue,
// plus published reference words, latency bounds, back-pressure, reseed and async reset scenarios.
module tb_mt_stream_gen;

    localparam int N = 624;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    logic        seed_valid64 = 1'b0;
    logic [63:0] seed64 = '0;
    logic        out_ready64 = 1'b0;
    logic        out_valid64;
    logic [63:0] out_data64;
    logic        busy64;

    int checks = 0;
    int failures = 0;
    int last_count = 0;
    int stall_events = 0;

    logic [31:0] expq[$];
    logic [31:0] word_log[$];
    logic [31:0] mdl[624];
    int          mti;

    mt_stream_gen dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    mt_stream_gen #(
        .W(64), .N(312), .M(156), .R(31), .A(64'hB5026F5AA96619E9),
        .U(29), .D(64'h5555555555555555), .S(17), .B(64'h71D67FFFEDA60000),
        .T(37), .C(64'hFFF7EEE000000000), .L(43), .F(64'd6364136223846793005)
    ) dut64 (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid64), .seed(seed64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64), .busy(busy64)
    );

    always #5 clk = ~clk;

    // Reference MT19937 in its textbook form.
    task automatic model_seed(input logic [31:0] s);
        mdl[0] = s;
        for (int i = 1; i < 624; i++) begin
            mdl[i] = 32'd1812433253 * (mdl[i-1] ^ (mdl[i-1] >> 30)) + 32'(i);
        end
        mti = 624;
    endtask

    task automatic model_next(output logic [31:0] r);
        logic [31:0] yv;
        if (mti >= 624) begin
            for (int k = 0; k < 624; k++) begin
                yv = (mdl[k] & 32'h80000000) | (mdl[(k + 1) % 624] & 32'h7FFFFFFF);
                mdl[k] = mdl[(k + 397) % 624] ^ (yv >> 1) ^ (yv[0] ? 32'h9908B0DF : 32'h0);
            end
            mti = 0;
        end
        yv = mdl[mti];
        mti++;
        yv = yv ^ (yv >> 11);
        yv = yv ^ ((yv << 7) & 32'h9D2C5680);
        yv = yv ^ ((yv << 15) & 32'hEFC60000);
        r  = yv ^ (yv >> 18);
    endtask

    // Scoreboard monitor: sampled mid-cycle, a visible valid&&ready is the transfer at the next edge.
    logic        stall_prev = 1'b0;
    logic        seed_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] exp_word;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !seed_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== stall_data) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: valid=%b data=%0d, required valid=1 data=%0d", out_valid, out_data, stall_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL scoreboard_extra: got word %0d, required no transfer", out_data);
                end else begin
                    exp_word = expq.pop_front();
                    if (out_data !== exp_word) begin
                        failures++;
                        $display("[TB] FAIL stream_word[%0d]: got %0d, required %0d", word_log.size(), out_data, exp_word);
                    end
                end
                word_log.push_back(out_data);
            end
            if (out_valid && !out_ready) stall_events++;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            seed_prev  = seed_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_seed(input logic [31:0] s, input int npush);
        logic [31:0] w;
        seed_valid = 1'b1;
        seed = s;
        step();
        seed_valid = 1'b0;
        last_count = word_log.size();
        word_log.delete();
        expq.delete();
        model_seed(s);
        for (int i = 0; i < npush; i++) begin
            model_next(w);
            expq.push_back(w);
        end
    endtask

    task automatic wait_first_valid(input int limit, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    task automatic consume(input int n, input int pct, input int budget);
        int cyc;
        cyc = 0;
        while (word_log.size() < n && cyc < budget) begin
            out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            step();
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        out_ready = 1'b1;
        #12;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, required 0", out_valid); end
        if (out_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_data: got %0d, required 0", out_data); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        if (out_valid64 !== 1'b0 || busy64 !== 1'b0) begin failures++; $display("[TB] FAIL reset_w64: valid=%b busy=%b, required 0 0", out_valid64, busy64); end
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("[TB] FAIL idle_before_seed: active cycles %0d, required 0", seen); end
        out_ready = 1'b0;
    endtask

    task automatic test_known_vectors();
        int cyc, zero_run, gaps;
        out_ready = 1'b1;
        drive_seed(32'd5489, 10000);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_init: got %b, required 1", busy); end
        wait_first_valid(2 * N + 20, cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc > 2 * N + 8) begin failures++; $display("[TB] FAIL first_latency: got %0d cycles, required <= %0d", cyc, 2 * N + 8); end
        zero_run = 0;
        gaps = 0;
        cyc = 0;
        while (word_log.size() < 10000 && cyc < 25000) begin
            if (!out_valid) begin
                zero_run++;
            end else if (zero_run > 0) begin
                gaps++;
                checks++;
                if (zero_run > N + 8 || (word_log.size() % N) != 0) begin
                    failures++;
                    $display("[TB] FAIL regen_gap: %0d idle cycles after word %0d, required <= %0d at a block boundary", zero_run, word_log.size(), N + 8);
                end
                zero_run = 0;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        checks += 2;
        if (word_log.size() != 10000) begin failures++; $display("[TB] FAIL stream_timeout: got %0d words, required 10000", word_log.size()); end
        if (gaps != 16) begin failures++; $display("[TB] FAIL gap_count: got %0d, required 16", gaps); end
        if (word_log.size() >= 10000) begin
            checks += 4;
            if (word_log[0] !== 32'd3499211612) begin failures++; $display("[TB] FAIL word1: got %0d, required 3499211612", word_log[0]); end
            if (word_log[1] !== 32'd581869302) begin failures++; $display("[TB] FAIL word2: got %0d, required 581869302", word_log[1]); end
            if (word_log[2] !== 32'd3890346734) begin failures++; $display("[TB] FAIL word3: got %0d, required 3890346734", word_log[2]); end
            if (word_log[9999] !== 32'd4123659995) begin failures++; $display("[TB] FAIL word10000: got %0d, required 4123659995", word_log[9999]); end
        end
    endtask

    task automatic test_backpressure();
        int stalls_before;
        drive_seed(32'd5489, 1500);
        stalls_before = stall_events;
        consume(1500, 30, 12000);
        checks += 2;
        if (word_log.size() != 1500) begin failures++; $display("[TB] FAIL bp_timeout: got %0d words, required 1500", word_log.size()); end
        if (stall_events == stalls_before) begin failures++; $display("[TB] FAIL bp_no_stall: got 0 stalled cycles, required > 0"); end
    endtask

    task automatic test_reseed_transfer();
        int cyc;
        drive_seed(32'd5489, 700);
        out_ready = 1'b1;
        cyc = 0;
        while (!(word_log.size() == 699 && out_valid) && cyc < 3000) begin
            step();
            cyc++;
        end
        checks++;
        if (word_log.size() != 699) begin failures++; $display("[TB] FAIL reseed_reach: got %0d words, required 699", word_log.size()); end
        drive_seed(32'd1, 30);
        checks += 2;
        if (last_count != 700) begin failures++; $display("[TB] FAIL reseed_word700: delivered %0d, required 700", last_count); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reseed_flush: valid=%b, required 0", out_valid); end
        wait_first_valid(2 * N + 20, cyc);
        consume(30, 100, 200);
        checks++;
        if (word_log.size() == 0 || word_log[0] !== 32'd1791095845) begin
            failures++;
            $display("[TB] FAIL reseed_first: got %0d, required 1791095845", (word_log.size() == 0) ? 32'd0 : word_log[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        seed_valid = 1'b1;
        seed = 32'd7;
        step();
        seed = 32'd9;
        step();
        drive_seed(32'd1, 5);
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy: got %b, required 1", busy); end
        wait_first_valid(2 * N + 20, cyc);
        if (out_valid !== 1'b1 || cyc > 2 * N + 8) begin failures++; $display("[TB] FAIL b2b_latency: got %0d cycles, required <= %0d", cyc, 2 * N + 8); end
        consume(5, 100, 50);
        checks++;
        if (word_log.size() == 0 || word_log[0] !== 32'd1791095845) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %0d, required 1791095845", (word_log.size() == 0) ? 32'd0 : word_log[0]);
        end
    endtask

    task automatic test_async_reset();
        int seen, cyc;
        drive_seed(32'd5489, 10);
        repeat (N + 100) step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL twist_busy: got %b, required 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_twist: busy=%b valid=%b, required 0 0", busy, out_valid); end
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (2 * N + 20) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin failures++; $display("[TB] FAIL post_reset_idle: active cycles %0d, required 0", seen); end
        drive_seed(32'd5489, 1);
        wait_first_valid(2 * N + 20, cyc);
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0) begin failures++; $display("[TB] FAIL async_run: valid=%b data=%0d, required 0 0", out_valid, out_data); end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_w64();
        int n64, cyc;
        logic [63:0] first, last;
        first = '0;
        last = '0;
        seed64 = 64'd5489;
        seed_valid64 = 1'b1;
        step();
        seed_valid64 = 1'b0;
        out_ready64 = 1'b1;
        n64 = 0;
        cyc = 0;
        while (n64 < 10000 && cyc < 30000) begin
            if (out_valid64) begin
                if (n64 == 0) first = out_data64;
                if (n64 == 9999) last = out_data64;
                n64++;
            end
            step();
            cyc++;
        end
        out_ready64 = 1'b0;
        checks += 3;
        if (n64 != 10000) begin failures++; $display("[TB] FAIL w64_timeout: got %0d words, required 10000", n64); end
        if (first !== 64'd14514284786278117030) begin failures++; $display("[TB] FAIL w64_word1: got %0d, required 14514284786278117030", first); end
        if (last !== 64'd9981545732273789042) begin failures++; $display("[TB] FAIL w64_word10000: got %0d, required 9981545732273789042", last); end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reseed_transfer();
        test_back_to_back();
        test_async_reset();
        test_w64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
